// File: rtl/sb_queue_seq.sv
// sb_queue_seq: per-queue enable / drain / reset sequencer for the switchboard queue array.
// Optional drain timeout is compiled in by defining SB_SEQ_TIMEOUT_EN.
module sb_queue_seq #(
    parameter int NUM_QUEUES     = 2,
    parameter int QW             = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [QW-1:0]         req_queue,
    input  logic [1:0]            req_op,
    input  logic [NUM_QUEUES-1:0] status_idle,
    output logic [NUM_QUEUES-1:0] cfg_enable,
    output logic [NUM_QUEUES-1:0] cfg_reset,
    output logic                  resp_valid,
    output logic [1:0]            resp_status,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RST, S_DONE} state_t;

    localparam logic [1:0] OP_ENABLE    = 2'd0;
    localparam logic [1:0] OP_DISABLE   = 2'd1;
    localparam logic [1:0] OP_RESTART   = 2'd3;
    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_BAD_INDEX = 2'd1;
    localparam logic [1:0] ST_TIMEOUT   = 2'd2;
    localparam int             RCW       = $clog2(RESET_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RESET_CYCLES - 1);
    localparam logic [31:0]    TMO_LIMIT = 32'(TIMEOUT_CYCLES);
`ifdef SB_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [NUM_QUEUES-1:0]   mask_q, mask_d;
    logic [1:0]              status_q, status_d;
    logic                    idle_prev_q, idle_prev_d;
    logic                    done_wait_q, done_wait_d;
    logic [31:0]             drain_cnt_q, drain_cnt_d;
    logic [RCW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [NUM_QUEUES-1:0]   cfg_enable_q, cfg_enable_d;
    logic [NUM_QUEUES-1:0]   cfg_reset_q, cfg_reset_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [1:0]              resp_status_q, resp_status_d;
    logic                    busy_q, busy_d;
    logic                    req_ready_q, req_ready_d;

    logic        idle_now, drain_ok, tmo_hit;
    logic [31:0] cnt_inc;

    // Idle must be seen on two consecutive samples so a stale idle from before the enable drop is ignored.
    assign idle_now = |(status_idle & mask_q);
    assign drain_ok = idle_now && idle_prev_q;
    assign cnt_inc  = sat_inc(drain_cnt_q);
    assign tmo_hit  = TMO_EN && (cnt_inc >= TMO_LIMIT);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        mask_d        = mask_q;
        status_d      = status_q;
        idle_prev_d   = idle_prev_q;
        done_wait_d   = done_wait_q;
        drain_cnt_d   = drain_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        cfg_enable_d  = cfg_enable_q;
        cfg_reset_d   = cfg_reset_q;
        resp_valid_d  = 1'b0;
        resp_status_d = resp_status_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    mask_d      = NUM_QUEUES'(1) << req_queue;
                    status_d    = ST_OK;
                    idle_prev_d = 1'b0;
                    done_wait_d = 1'b0;
                    drain_cnt_d = '0;
                    rst_cnt_d   = '0;
                    if (32'(req_queue) >= 32'(NUM_QUEUES)) begin
                        status_d      = ST_BAD_INDEX;
                        state_d       = S_DONE;
                        resp_valid_d  = 1'b1;
                        resp_status_d = ST_BAD_INDEX;
                    end else if (req_op == OP_ENABLE) begin
                        // Response follows one cycle after the enable lands.
                        cfg_enable_d = cfg_enable_q | mask_d;
                        done_wait_d  = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        cfg_enable_d = cfg_enable_q & ~mask_d;
                        state_d      = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = cnt_inc;
                idle_prev_d = idle_now;
                if (drain_ok || tmo_hit) begin
                    status_d = drain_ok ? ST_OK : ST_TIMEOUT;
                    if (op_q == OP_DISABLE) begin
                        state_d       = S_DONE;
                        resp_valid_d  = 1'b1;
                        resp_status_d = status_d;
                    end else begin
                        state_d     = S_RST;
                        cfg_reset_d = mask_q;
                    end
                end
            end
            S_RST: begin
                rst_cnt_d = rst_cnt_q + RCW'(1);
                if (rst_cnt_q == RST_LAST) begin
                    cfg_reset_d = '0;
                    if (op_q == OP_RESTART) begin
                        cfg_enable_d = cfg_enable_q | mask_q;
                    end
                    state_d       = S_DONE;
                    resp_valid_d  = 1'b1;
                    resp_status_d = status_q;
                end
            end
            S_DONE: begin
                if (done_wait_q) begin
                    done_wait_d   = 1'b0;
                    resp_valid_d  = 1'b1;
                    resp_status_d = status_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_ENABLE;
            mask_q        <= '0;
            status_q      <= ST_OK;
            idle_prev_q   <= 1'b0;
            done_wait_q   <= 1'b0;
            drain_cnt_q   <= '0;
            rst_cnt_q     <= '0;
            cfg_enable_q  <= '0;
            cfg_reset_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= ST_OK;
            busy_q        <= 1'b0;
            req_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            mask_q        <= mask_d;
            status_q      <= status_d;
            idle_prev_q   <= idle_prev_d;
            done_wait_q   <= done_wait_d;
            drain_cnt_q   <= drain_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            cfg_enable_q  <= cfg_enable_d;
            cfg_reset_q   <= cfg_reset_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign cfg_enable  = cfg_enable_q;
    assign cfg_reset   = cfg_reset_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign busy        = busy_q;
    assign req_ready   = req_ready_q;

endmodule

// File: tb/tb_sb_queue_seq.sv
// Bench for sb_queue_seq: schedule-based reference model with a per-cycle compare, plus directed literal checks.
module tb_sb_queue_seq;
    localparam int NQ      = 2;
    localparam int QWB     = 2;
    localparam int RC      = 4;
    localparam int TMO_CYC = 16;
`ifdef SB_SEQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    localparam int T4_FIRST  = TMO ? 16 : 32;
    localparam int T4_RESP   = TMO ? 20 : 36;
    localparam int T4_STATUS = TMO ? 2 : 0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [QWB-1:0] req_queue = '0;
    logic [1:0]     req_op = '0;
    logic [NQ-1:0]  status_idle = '0;
    logic [NQ-1:0]  cfg_enable;
    logic [NQ-1:0]  cfg_reset;
    logic           resp_valid;
    logic [1:0]     resp_status;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sb_queue_seq #(
        .NUM_QUEUES(NQ), .QW(QWB), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_queue(req_queue), .req_op(req_op), .status_idle(status_idle),
        .cfg_enable(cfg_enable), .cfg_reset(cfg_reset), .resp_valid(resp_valid),
        .resp_status(resp_status), .busy(busy)
    );

    function automatic void chk(string nm, int unsigned got, int unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endfunction

    function automatic logic [NQ-1:0] bitq(int i);
        return NQ'(1) << i;
    endfunction

    // Reference model: each command is a timeline measured in edges since acceptance.
    logic [NQ-1:0] m_en  = '0;
    logic [NQ-1:0] m_rst = '0;
    bit            m_rv  = 1'b0;
    logic [1:0]    m_rs  = 2'd0;
    logic [1:0]    m_st  = 2'd0;
    logic [1:0]    m_op  = 2'd0;
    bit            act   = 1'b0;
    int            age   = 0;
    int            mq    = 0;
    int            dend  = -1;
    bit            hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en  = '0;
            m_rst = '0;
            m_rv  = 1'b0;
            m_rs  = 2'd0;
            act   = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (!act) begin
                if (req_valid) begin
                    act  = 1'b1;
                    age  = 0;
                    m_op = req_op;
                    mq   = int'(req_queue);
                    dend = -1;
                    m_st = 2'd0;
                    hist.delete();
                    if (mq >= NQ) begin
                        m_rv = 1'b1;
                        m_rs = 2'd1;
                    end else if (m_op == 2'd0) begin
                        m_en = m_en | bitq(mq);
                    end else begin
                        m_en = m_en & ~bitq(mq);
                    end
                end
            end else begin
                age++;
                if (mq >= NQ) begin
                    act = 1'b0;
                end else if (m_op == 2'd0) begin
                    if (age == 1) begin
                        m_rv = 1'b1;
                        m_rs = 2'd0;
                    end else begin
                        act = 1'b0;
                    end
                end else if (dend < 0) begin
                    hist.push_back((status_idle & bitq(mq)) != '0);
                    if (hist.size() >= 2 && hist[hist.size()-1] && hist[hist.size()-2]) begin
                        dend = age;
                        m_st = 2'd0;
                    end else if (TMO && age >= TMO_CYC) begin
                        dend = age;
                        m_st = 2'd2;
                    end
                    if (dend == age) begin
                        if (m_op == 2'd1) begin
                            m_rv = 1'b1;
                            m_rs = m_st;
                        end else begin
                            m_rst = bitq(mq);
                        end
                    end
                end else if (m_op == 2'd1) begin
                    act = 1'b0;
                end else if (age - dend == RC) begin
                    m_rst = '0;
                    if (m_op == 2'd3) m_en = m_en | bitq(mq);
                    m_rv = 1'b1;
                    m_rs = m_st;
                end else if (age - dend == RC + 1) begin
                    act = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_enable", cfg_enable, m_en);
        chk("cmp_reset", cfg_reset, m_rst);
        chk("cmp_resp_valid", resp_valid, m_rv);
        if (m_rv) chk("cmp_resp_status", resp_status, m_rs);
        chk("cmp_busy", busy, act);
        chk("cmp_ready", req_ready, !act);
        chk("cmp_reset_onehot", ($countones(cfg_reset) <= 1), 1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int q, input logic [1:0] op);
        req_valid = 1'b1;
        req_queue = QWB'(q);
        req_op    = op;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int first;
        int hi;
        int seen;
        int rcount;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_enable", cfg_enable, 0);
        chk("rst_reset", cfg_reset, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_status", resp_status, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        tick();

        // ENABLE q1
        send(1, 2'd0);
        #1;
        chk("en_t1_enable", cfg_enable, 2'b10);
        chk("en_t1_ready", req_ready, 0);
        chk("en_t1_resp", resp_valid, 0);
        tick(); #1;
        chk("en_t2_resp", resp_valid, 1);
        chk("en_t2_status", resp_status, 0);
        chk("en_t2_ready", req_ready, 0);
        tick(); #1;
        chk("en_t3_resp", resp_valid, 0);
        chk("en_t3_ready", req_ready, 1);

        // RESTART q0, idle rises late
        send(0, 2'd3);
        #1;
        chk("rs_drop", cfg_enable, 2'b10);
        repeat (4) tick();
        status_idle[0] = 1'b1;
        first = 0; hi = 0; seen = 0;
        for (int k = 5; k <= 30 && seen == 0; k++) begin
            tick(); #1;
            chk("rs_q1_hold", cfg_enable[1], 1);
            if (cfg_reset[0]) begin
                hi++;
                if (first == 0) first = k;
            end
            if (resp_valid) begin
                seen = k;
                chk("rs_enable_back", cfg_enable, 2'b11);
                chk("rs_status", resp_status, 0);
                chk("rs_reset_fell", cfg_reset, 0);
            end
        end
        chk("rs_rst_first", first, 6);
        chk("rs_rst_len", hi, 4);
        chk("rs_resp_cycle", seen, 10);
        tick(); #1;
        chk("rs_ready", req_ready, 1);

        // bad index
        send(3, 2'd0);
        #1;
        chk("bad_resp", resp_valid, 1);
        chk("bad_status", resp_status, 1);
        chk("bad_enable", cfg_enable, 2'b11);
        chk("bad_ready", req_ready, 0);
        tick(); #1;
        chk("bad_resp_end", resp_valid, 0);
        chk("bad_ready_back", req_ready, 1);

        // RESET q1 with idle held low
        send(1, 2'd2);
        #1;
        chk("tmo_drop", cfg_enable, 2'b01);
        first = 0; hi = 0; seen = 0;
        for (int k = 1; k <= 60 && seen == 0; k++) begin
            tick();
            if (k == 30) status_idle[1] = 1'b1;
            #1;
            if (cfg_reset[1]) begin
                hi++;
                if (first == 0) first = k;
            end
            if (resp_valid) begin
                seen = k;
                chk("tmo_status", resp_status, T4_STATUS);
                chk("tmo_enable", cfg_enable, 2'b01);
            end
        end
        chk("tmo_rst_first", first, T4_FIRST);
        chk("tmo_rst_len", hi, 4);
        chk("tmo_resp_cycle", seen, T4_RESP);
        tick(); #1;
        chk("tmo_ready", req_ready, 1);

        // async reset during RST
        send(0, 2'd2);
        tick();
        tick();
        #1;
        chk("ar_pre_reset", cfg_reset, 2'b01);
        rst = 1'b1;
        #1;
        chk("ar_reset", cfg_reset, 0);
        chk("ar_enable", cfg_enable, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", req_ready, 1);
        chk("ar_resp", resp_valid, 0);
        tick();
        rst = 1'b0;
        rcount = 0;
        repeat (3) begin
            tick(); #1;
            if (resp_valid) rcount++;
        end
        chk("ar_no_resp", rcount, 0);
        send(1, 2'd0);
        #1;
        chk("ar_next_enable", cfg_enable, 2'b10);
        tick(); #1;
        chk("ar_next_resp", resp_valid, 1);
        tick();

        // DISABLE q0 with idle 1,0,1,1 and stray requests while busy
        send(0, 2'd1);
        tick();
        status_idle[0] = 1'b0;
        req_valid = 1'b1; req_queue = 2'd1; req_op = 2'd1;
        tick();
        status_idle[0] = 1'b1;
        req_valid = 1'b0;
        tick(); #1;
        chk("dis_wait_resp", resp_valid, 0);
        chk("dis_wait_busy", busy, 1);
        tick(); #1;
        chk("dis_resp", resp_valid, 1);
        chk("dis_status", resp_status, 0);
        chk("dis_enable", cfg_enable, 2'b10);
        rcount = 0;
        repeat (6) begin
            tick(); #1;
            if (resp_valid) rcount++;
        end
        chk("dis_no_extra", rcount, 0);
        chk("dis_final_enable", cfg_enable, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
